// File: rtl/pulse_sequencer_pkg.sv
// Shared constants, state encoding and table-entry field positions for the
// pulse sequencer.
package pulse_sequencer_pkg;

  localparam int N_SLOTS = 8;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  localparam int DLY_MSB = 31;
  localparam int DLY_LSB = 16;
  localparam int WID_MSB = 15;
  localparam int WID_LSB = 0;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(N_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_DELAY = 3'd3,
    S_HIGH  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Control, table-read and status signals of the pulse sequencer.
interface pulse_sequencer_if;
  import pulse_sequencer_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W:0]   cfg_len;
  logic              tbl_rd;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              pulse_out;
  logic [ADDR_W-1:0] slot_idx;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output start, abort, cfg_len, tbl_data,
    input  tbl_rd, tbl_addr, pulse_out, slot_idx, busy, done, overrun
  );

  modport slave (
    input  start, abort, cfg_len, tbl_data,
    output tbl_rd, tbl_addr, pulse_out, slot_idx, busy, done, overrun
  );

endinterface

// File: rtl/pulse_sequencer_timer.sv
// pulse_timer: 16-bit loadable down-counter that stops at zero; shared by the
// DELAY and HIGH phases.
module pulse_timer
  import pulse_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Plays back the pulse table: fetches each entry, waits its delay, then drives
// pulse_out for its width. done/busy are registered copies of the state.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pulse_sequencer_if.slave bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0]  width_reg, width_next;
  logic              overrun_reg, overrun_next;
  logic              pulse_reg, done_reg, busy_reg;
  logic              tmr_load, tmr_zero, advance, last_entry;
  logic [CNT_W-1:0]  tmr_val, ent_delay, ent_width;
  logic [ADDR_W:0]   start_len;

  assign ent_delay  = bus.tbl_data[DLY_MSB:DLY_LSB];
  assign ent_width  = bus.tbl_data[WID_MSB:WID_LSB];
  assign start_len  = clamp_len(bus.cfg_len);
  assign last_entry = ({1'b0, idx_reg} == (len_reg - (ADDR_W+1)'(1)));

  pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    width_next   = width_reg;
    overrun_next = overrun_reg;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    advance      = 1'b0;
    if (bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            len_next     = start_len;
            idx_next     = '0;
            overrun_next = 1'b0;
            state_next   = (start_len == '0) ? S_FIN : S_FETCH;
          end
        end
        S_FETCH: state_next = S_LOAD;
        S_LOAD: begin
          width_next = ent_width;
          if (ent_delay != '0) begin
            tmr_load   = 1'b1;
            tmr_val    = ent_delay - CNT_W'(1);
            state_next = S_DELAY;
          end else if (ent_width != '0) begin
            tmr_load   = 1'b1;
            tmr_val    = ent_width - CNT_W'(1);
            state_next = S_HIGH;
          end else begin
            advance = 1'b1;
          end
        end
        S_DELAY: begin
          if (tmr_zero) begin
            if (width_reg != '0) begin
              tmr_load   = 1'b1;
              tmr_val    = width_reg - CNT_W'(1);
              state_next = S_HIGH;
            end else begin
              advance = 1'b1;
            end
          end
        end
        S_HIGH:  advance = tmr_zero;
        S_FIN:   state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
      if (state_reg != S_IDLE && bus.start) begin
        overrun_next = 1'b1;
      end
      if (advance) begin
        if (last_entry) begin
          state_next = S_FIN;
        end else begin
          idx_next   = idx_reg + ADDR_W'(1);
          state_next = S_FETCH;
        end
      end
    end
  end

  // pulse_out follows the next state so it is high exactly during HIGH cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      len_reg     <= '0;
      idx_reg     <= '0;
      width_reg   <= '0;
      overrun_reg <= 1'b0;
      pulse_reg   <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      width_reg   <= width_next;
      overrun_reg <= overrun_next;
      pulse_reg   <= (state_next == S_HIGH);
      done_reg    <= (state_reg == S_FIN) && !bus.abort;
      busy_reg    <= (state_reg != S_IDLE);
    end
  end

  assign bus.tbl_rd    = (state_reg == S_FETCH);
  assign bus.tbl_addr  = idx_reg;
  assign bus.pulse_out = pulse_reg;
  assign bus.slot_idx  = (state_reg != S_IDLE) ? idx_reg : '0;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: a behavioural table RAM with registered
// read, cycle-indexed capture of outputs, and hand-computed expected patterns.
module tb_pulse_sequencer;
  import pulse_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  pulse_sequencer_if bus ();

  pulse_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [N_SLOTS];

  always_ff @(posedge clk) begin
    if (bus.tbl_rd) bus.tbl_data <= mem[bus.tbl_addr];
  end

  logic [31:0] pulse_v, rd_v, done_v, busy_v, ovr_v, addr_log;
  int          rd_count;
  logic [2:0]  snap_slot;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Accepts a start at the next edge, then records n cycles (k=0 is the
  // cycle right after the accepting edge). start is re-pulsed at poke_k.
  task automatic run_capture(input logic [3:0] len, input int n, input int poke_k, input int snap_k);
    bus.cfg_len = len;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_v = '0; rd_v = '0; done_v = '0; busy_v = '0; ovr_v = '0; addr_log = '0;
    rd_count = 0; snap_slot = '0;
    for (int k = 0; k < n; k++) begin
      pulse_v[k] = bus.pulse_out;
      rd_v[k]    = bus.tbl_rd;
      done_v[k]  = bus.done;
      busy_v[k]  = bus.busy;
      ovr_v[k]   = bus.overrun;
      if (bus.tbl_rd) begin
        addr_log = {addr_log[28:0], bus.tbl_addr};
        rd_count++;
      end
      if (k == snap_k) snap_slot = bus.slot_idx;
      bus.start = (k == poke_k);
      tick();
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, bus.tbl_rd, bus.pulse_out, bus.busy, bus.done, bus.overrun, bus.slot_idx, bus.tbl_addr};
  endfunction

  initial begin
    int dcnt;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_len = '0;
    for (int i = 0; i < N_SLOTS; i++) mem[i] = '0;
    repeat (3) tick();
    check("reset_outs", outs(), 32'h0);
    rst_n = 1'b1;
    tick();

    // single entry, delay 3, width 5
    mem[0] = 32'h0003_0005;
    run_capture(4'd1, 13, -1, -1);
    check("t1_rd", rd_v, 32'h0001);
    check("t1_addr", addr_log, 32'h0);
    check("t1_pulse", pulse_v, 32'h03E0);
    check("t1_done", done_v, 32'h0800);
    check("t1_busy", busy_v, 32'h0FFE);

    // three entries, middle one produces no pulse
    mem[0] = 32'h0000_0002;
    mem[1] = 32'h0001_0000;
    mem[2] = 32'h0002_0001;
    run_capture(4'd3, 16, -1, 9);
    check("t2_pulse", pulse_v, 32'h080C);
    check("t2_rd", rd_v, 32'h0091);
    check("t2_addr", addr_log, 32'h000A);
    check("t2_done", done_v, 32'h2000);
    check("t2_slot", {29'd0, snap_slot}, 32'd2);

    // zero length: no read, immediate completion
    run_capture(4'd0, 4, -1, -1);
    check("t3_len0_rd", rd_v, 32'h0);
    check("t3_len0_done", done_v, 32'h0002);
    check("t3_len0_pulse", pulse_v, 32'h0);

    // length above table depth is clamped to 8 reads
    for (int i = 0; i < N_SLOTS; i++) mem[i] = '0;
    run_capture(4'd12, 20, -1, -1);
    check("t3_clamp_cnt", 32'(rd_count), 32'd8);
    check("t3_clamp_addr", addr_log, 32'o01234567);
    check("t3_clamp_done", done_v, 32'h0002_0000);

    // abort during the 4th HIGH cycle of a width-10 pulse
    mem[0] = 32'h0000_000A;
    bus.cfg_len = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("t4_pulse_pre", {31'd0, bus.pulse_out}, 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4_pulse_post", {31'd0, bus.pulse_out}, 32'd0);
    tick();
    check("t4_busy", {31'd0, bus.busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dcnt++;
      tick();
    end
    check("t4_no_done", 32'(dcnt), 32'd0);
    mem[0] = 32'h0000_0001;
    run_capture(4'd1, 8, -1, -1);
    check("t4_replay_cnt", 32'(rd_count), 32'd1);
    check("t4_replay_addr", addr_log, 32'h0);
    check("t4_replay_pls", pulse_v, 32'h0004);

    // start while busy sets overrun without disturbing the sequence
    mem[0] = 32'h0003_0005;
    run_capture(4'd1, 13, 2, -1);
    check("t5_ovr", ovr_v, 32'h1FF8);
    check("t5_pulse", pulse_v, 32'h03E0);
    check("t5_done", done_v, 32'h0800);
    run_capture(4'd0, 4, -1, -1);
    check("t5_ovr_clear", ovr_v, 32'h0);

    // reset mid-DELAY, then start+abort together in IDLE
    mem[0] = 32'h0005_0002;
    bus.cfg_len = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_reset_outs", outs(), 32'h0);
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t6_sa_rd", {31'd0, bus.tbl_rd}, 32'd0);
    tick();
    check("t6_sa_outs", outs(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
